rtclock_tsu: RTL

//  Next-generation real-time clock and timestamp unit.
//  - Keeps a sec/nsec time-of-day with a sub-ns fractional increment, so clock drift can be trimmed.
//  - Supports set, step-adjust and PPS discipline with a measured PPS offset.
//  - N_CAP event inputs are timestamped into hold registers for the AXI register bank and packet generator/checker cores.

---
 rtl/rtclock_pkg.sv | 16 +
 rtl/rtclock_capture.sv | 70 +++++++
 rtl/rtclock_tsu.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/rtclock_pkg.sv
// rtl/rtclock_pkg.sv - shared constants and types for the real-time clock / timestamp unit
package rtclock_pkg;

    localparam int NSEC_W = 30;
    localparam logic [NSEC_W-1:0] NSEC_MODULO = 30'd1000000000;
    localparam logic [NSEC_W-1:0] NSEC_HALF   = 30'd500000000;

    // Which source updates time-of-day this cycle, in rising priority order
    typedef enum logic [1:0] {
        UPD_TICK,
        UPD_ADJ,
        UPD_PPS,
        UPD_SET
    } upd_sel_e;

endpackage

// File: rtl/rtclock_capture.sv
// rtl/rtclock_capture.sv - one timestamp capture slot: rising-edge detect, valid/overflow, hold registers
module rtclock_capture
    import rtclock_pkg::*;
#(
    parameter int SEC_W = 48
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              evt,
    input  logic              ack,
    input  logic [SEC_W-1:0]  sec,
    input  logic [NSEC_W-1:0] nsec,
    output logic              valid,
    output logic              ovf,
    output logic [SEC_W-1:0]  cap_sec,
    output logic [NSEC_W-1:0] cap_nsec
);

    logic              evt_q;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [NSEC_W-1:0] nsec_q, nsec_d;
    logic              rise;

    assign rise = evt & ~evt_q;

    always_comb begin
        valid_d = valid_q;
        ovf_d   = ovf_q;
        sec_d   = sec_q;
        nsec_d  = nsec_q;
        if (ack) begin
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end
        // An ack in the same cycle frees the slot for the incoming event
        if (rise) begin
            if (valid_q && !ack) begin
                ovf_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                sec_d   = sec;
                nsec_d  = nsec;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            evt_q   <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            sec_q   <= '0;
            nsec_q  <= '0;
        end else begin
            evt_q   <= evt;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            sec_q   <= sec_d;
            nsec_q  <= nsec_d;
        end
    end

    assign valid    = valid_q;
    assign ovf      = ovf_q;
    assign cap_sec  = sec_q;
    assign cap_nsec = nsec_q;

endmodule

// File: rtl/rtclock_tsu.sv
// rtl/rtclock_tsu.sv - sec/nsec time-of-day with fractional trim, set/adjust/PPS discipline, event capture; RTCLOCK_PPS_OUT_EN enables pps_out
module rtclock_tsu
    import rtclock_pkg::*;
#(
    parameter int SEC_W  = 48,
    parameter int FRAC_W = 16,
    parameter int N_CAP  = 2
`ifdef RTCLOCK_PPS_OUT_EN
    ,
    parameter int unsigned PPS_WIDTH_NS = 100000000
`endif
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [7:0]               cfg_inc_ns,
    input  logic [FRAC_W-1:0]        cfg_inc_frac,
    input  logic                     cfg_pps_en,
    input  logic                     pps_in,
    input  logic                     set_valid,
    input  logic [SEC_W-1:0]         set_sec,
    input  logic [NSEC_W-1:0]        set_nsec,
    input  logic                     adj_valid,
    input  logic                     adj_neg,
    input  logic [NSEC_W-1:0]        adj_nsec,
    output logic [SEC_W-1:0]         sec,
    output logic [NSEC_W-1:0]        nsec,
    output logic                     time_valid,
    output logic [30:0]              pps_offset,
    output logic                     pps_stb,
    input  logic [N_CAP-1:0]         cap_evt,
    input  logic [N_CAP-1:0]         cap_ack,
    output logic [N_CAP-1:0]         cap_valid,
    output logic [N_CAP-1:0]         cap_ovf,
    output logic [N_CAP*SEC_W-1:0]   cap_sec,
    output logic [N_CAP*NSEC_W-1:0]  cap_nsec,
    output logic                     pps_out
);

    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [NSEC_W-1:0] nsec_q, nsec_d;
    logic [FRAC_W-1:0] frac_q, frac_d;
    logic              tv_q, tv_d;
    logic [30:0]       off_q, off_d;
    logic              stb_q, stb_d;
    logic              pps_in_q;
    upd_sel_e          upd_sel;

    // Free-running tick: {nsec,frac} + {inc_ns,inc_frac}, ns part 32 bits wide
    logic [FRAC_W:0]   frac_sum;
    logic [31:0]       ns_sum;
    logic              ns_wrap;
    logic [NSEC_W-1:0] nsec_next;
    logic [SEC_W-1:0]  sec_next;

    assign frac_sum  = {1'b0, frac_q} + {1'b0, cfg_inc_frac};
    assign ns_sum    = {2'b00, nsec_q} + {24'd0, cfg_inc_ns} + {31'd0, frac_sum[FRAC_W]};
    assign ns_wrap   = ns_sum >= {2'b00, NSEC_MODULO};
    assign nsec_next = ns_wrap ? ns_sum[NSEC_W-1:0] - NSEC_MODULO : ns_sum[NSEC_W-1:0];
    assign sec_next  = sec_q + SEC_W'(ns_wrap);

    // Step adjust applies on top of the unwrapped tick; bit 32 flags a negative result
    logic [32:0]       adj_sum;
    logic              adj_lo, adj_hi;
    logic [NSEC_W-1:0] nsec_adj;
    logic [SEC_W-1:0]  sec_adj;

    assign adj_sum  = adj_neg ? {1'b0, ns_sum} - {3'b000, adj_nsec}
                              : {1'b0, ns_sum} + {3'b000, adj_nsec};
    assign adj_lo   = adj_sum[32];
    assign adj_hi   = !adj_lo && (adj_sum[31:0] >= {2'b00, NSEC_MODULO});
    assign nsec_adj = adj_hi ? adj_sum[NSEC_W-1:0] - NSEC_MODULO :
                      adj_lo ? adj_sum[NSEC_W-1:0] + NSEC_MODULO : adj_sum[NSEC_W-1:0];
    assign sec_adj  = adj_hi ? sec_q + SEC_W'(1) :
                      adj_lo ? sec_q - SEC_W'(1) : sec_q;

    // PPS error: late edges (past half second) are reported negative and round sec up
    logic              pps_edge;
    logic              pps_late;
    logic [30:0]       pps_err;

    assign pps_edge = cfg_pps_en & pps_in & ~pps_in_q;
    assign pps_late = nsec_next >= NSEC_HALF;
    assign pps_err  = {1'b0, nsec_next} - (pps_late ? {1'b0, NSEC_MODULO} : 31'd0);

    always_comb begin
        upd_sel = UPD_TICK;
        if (set_valid)      upd_sel = UPD_SET;
        else if (pps_edge)  upd_sel = UPD_PPS;
        else if (adj_valid) upd_sel = UPD_ADJ;
    end

    always_comb begin
        sec_d  = sec_next;
        nsec_d = nsec_next;
        frac_d = frac_sum[FRAC_W-1:0];
        tv_d   = tv_q;
        off_d  = off_q;
        stb_d  = 1'b0;
        case (upd_sel)
            UPD_SET: begin
                sec_d  = set_sec;
                nsec_d = set_nsec;
                frac_d = '0;
                tv_d   = 1'b1;
            end
            UPD_PPS: begin
                sec_d  = sec_next + SEC_W'(pps_late);
                nsec_d = {22'd0, cfg_inc_ns};
                frac_d = '0;
                tv_d   = 1'b1;
                off_d  = pps_err;
                stb_d  = 1'b1;
            end
            UPD_ADJ: begin
                sec_d  = sec_adj;
                nsec_d = nsec_adj;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sec_q    <= '0;
            nsec_q   <= '0;
            frac_q   <= '0;
            tv_q     <= 1'b0;
            off_q    <= '0;
            stb_q    <= 1'b0;
            pps_in_q <= 1'b0;
        end else begin
            sec_q    <= sec_d;
            nsec_q   <= nsec_d;
            frac_q   <= frac_d;
            tv_q     <= tv_d;
            off_q    <= off_d;
            stb_q    <= stb_d;
            pps_in_q <= pps_in;
        end
    end

    assign sec        = sec_q;
    assign nsec       = nsec_q;
    assign time_valid = tv_q;
    assign pps_offset = off_q;
    assign pps_stb    = stb_q;

    for (genvar i = 0; i < N_CAP; i++) begin : g_cap
        rtclock_capture #(
            .SEC_W (SEC_W)
        ) u_cap (
            .clk      (clk),
            .resetn   (resetn),
            .evt      (cap_evt[i]),
            .ack      (cap_ack[i]),
            .sec      (sec_q),
            .nsec     (nsec_q),
            .valid    (cap_valid[i]),
            .ovf      (cap_ovf[i]),
            .cap_sec  (cap_sec[i*SEC_W +: SEC_W]),
            .cap_nsec (cap_nsec[i*NSEC_W +: NSEC_W])
        );
    end

`ifdef RTCLOCK_PPS_OUT_EN
    logic pps_out_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) pps_out_q <= 1'b0;
        else         pps_out_q <= tv_q && ({2'b00, nsec_q} < 32'(PPS_WIDTH_NS));
    end

    assign pps_out = pps_out_q;
`else
    assign pps_out = 1'b0;
`endif

endmodule
